reg_ram_scan: RTL
=================

Name: reg_ram_scan

Overview:
- Parametrised register-RAM scanner; successor of the fixed-map register poller.
- Polls a flags word in the host-shared register RAM. When the host sets the update bit, it reads NUM_RD config words into a staging bank, writes NUM_WR status words back, and acknowledges by clearing the update bit.
- Commits all config words to the outputs in one atomic cycle, so downstream consumers never see a partial update.
- Sits between the host register RAM port and camera/trigger/DMA config consumers.

Parameters:
- DW, 32, data word width.
- AW, 8, register RAM address width.
- NUM_RD, 8, number of config words read per scan (1..2^AW-2).
- NUM_WR, 2, number of status words written per scan (0 allowed: write phase skipped).
- FLAGS_ADDR, 0, address of the flags word.
- BASE_RD, 1, address of config word 0; word i is at BASE_RD+i.
- BASE_WR, 16, address of status word 0; word j is at BASE_WR+j.
- CFG_INIT, 0, flattened NUM_RD*DW reset value of cfg; word i is at bits [i*DW +: DW].
- CLR_ON_ACK, 1, 1 = ack write clears flags bit0; 0 = no ack write.

Ports:
- c, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, polling enable.
- reg_ram_addr, out, AW, RAM address.
- reg_ram_wr, out, 1, RAM write enable.
- reg_ram_d, out, DW, RAM write data.
- reg_ram_q, in, DW, RAM read data; synchronous, valid one cycle after the address.
- status_in, in, NUM_WR*DW, status words; word j at bits [j*DW +: DW].
- flags, out, DW, last flags word read that had bit0=1.
- cfg, out, NUM_RD*DW, committed config words.
- cfg_update, out, 1, one-cycle pulse on the commit cycle.
- busy, out, 1, high from CHECK-with-go through COMMIT.

Behaviour:
- Reset (synchronous, rst=1):
  - state=IDLE; cfg=CFG_INIT; staging bank=CFG_INIT; flags=0.
  - cfg_update=0, busy=0, reg_ram_wr=0.
  - Reset mid-scan aborts immediately: no further RAM writes, cfg retains CFG_INIT, the flags bit is not cleared.
- IDLE:
  - Drive addr=FLAGS_ADDR, wr=0.
  - en=1 -> CHECK; en=0 -> stay in IDLE.
- CHECK:
  - reg_ram_q holds flags. If q[0]=1: capture flags<=q, raise busy, set idx=0, go to RD. Otherwise return to IDLE.
  - Poll period when idle is 2 cycles.
- RD (pipelined, NUM_RD+1 cycles):
  - Cycle k (0..NUM_RD-1) drives addr=BASE_RD+k.
  - Cycle k (1..NUM_RD) captures staging[k-1]<=reg_ram_q.
  - The extra final cycle (RD_LAST) only captures.
  - Then go to WR, or to ACK if NUM_WR=0.
- WR (NUM_WR cycles):
  - Cycle j drives addr=BASE_WR+j, wr=1, d=status_in word j, sampled in that same cycle.
- ACK (1 cycle):
  - If CLR_ON_ACK=1: addr=FLAGS_ADDR, wr=1, d={flags[DW-1:1],1'b0}.
  - If CLR_ON_ACK=0: wr=0.
  - Host writes to the flags word made between CHECK and ACK are overwritten; the host driver must not touch the flags word while bit0=1.
- COMMIT (1 cycle):
  - cfg<=staging, all words in the same edge; cfg_update=1 this cycle, 0 in every other cycle.
  - busy is 1 in this cycle and 0 next cycle; then go to IDLE.
- Scan length from CHECK-with-go to the cfg_update cycle: NUM_RD+NUM_WR+4 cycles (CHECK, NUM_RD+1 RD cycles, NUM_WR WR cycles, ACK, COMMIT).
- en=0 during a scan does not abort it; the FSM finishes, then stays in IDLE until en=1.
- Address arithmetic is AW-bit and wraps modulo 2^AW. Overlap of the read and write windows is a configuration error (not checked in RTL).
- reg_ram_wr=1 only in WR and ACK. In all other states reg_ram_d=0.
- cfg never changes outside COMMIT or reset.

Test Plan (DW=32, AW=8, NUM_RD=4, NUM_WR=2, FLAGS_ADDR=0, BASE_RD=1, BASE_WR=8, CFG_INIT word i = 16'h100+i, CLR_ON_ACK=1):
- Reset then idle with RAM[0]=0 -> addr stays 0 and alternates IDLE/CHECK every 2 cycles; cfg words = 0x100..0x103; no writes; cfg_update never pulses.
- RAM[0]=0x5, RAM[1..4]=0xA0..0xA3, status_in={0xBEEF,0xCAFE} -> writes RAM[8]=0xCAFE and RAM[9]=0xBEEF; ack writes RAM[0]=0x4; cfg=0xA0..0xA3 all change on one edge; cfg_update pulses 10 cycles after CHECK; flags=0x5.
- Sample cfg every cycle during the scan -> cfg equals the old values until the commit edge; no mixed old/new word set is ever observed.
- Assert rst during the RD phase -> the next cycle cfg=CFG_INIT and busy=0; RAM[0] keeps bit0=1; after reset release the scan restarts and completes normally.
- Drop en during the WR phase -> the scan completes (ack and commit occur), then addr holds 0 with no CHECK cycles; raising en resumes polling.
- Rebuild with NUM_WR=0 and CLR_ON_ACK=0 -> no RAM writes ever; cfg_update pulses 8 cycles after CHECK; the scan repeats continuously while RAM[0] bit0=1.

Source files
------------

// File: rtl/reg_ram_scan_if.sv
// Host register RAM port as seen by the scanner: address, write enable,
// write data and the synchronous read data returned one cycle later.
`timescale 1ns/1ps
interface reg_ram_scan_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic [AW-1:0] reg_ram_addr;
    logic          reg_ram_wr;
    logic [DW-1:0] reg_ram_d;
    logic [DW-1:0] reg_ram_q;

    modport master (
        output reg_ram_addr,
        output reg_ram_wr,
        output reg_ram_d,
        input  reg_ram_q
    );

    modport slave (
        input  reg_ram_addr,
        input  reg_ram_wr,
        input  reg_ram_d,
        output reg_ram_q
    );
endinterface

// File: rtl/reg_ram_scan.sv
// Register-RAM scanner. Polls the flags word; when the host raises bit0 it
// reads NUM_RD config words into a staging bank, writes NUM_WR status words,
// acknowledges by clearing bit0 and then publishes every config word on the
// same edge so consumers never observe a half-updated set.
`timescale 1ns/1ps
module reg_ram_scan #(
    parameter int                   DW         = 32,
    parameter int                   AW         = 8,
    parameter int                   NUM_RD     = 8,
    parameter int                   NUM_WR     = 2,
    parameter int                   FLAGS_ADDR = 0,
    parameter int                   BASE_RD    = 1,
    parameter int                   BASE_WR    = 16,
    parameter logic [NUM_RD*DW-1:0] CFG_INIT   = '0,
    parameter bit                   CLR_ON_ACK = 1'b1,
    // A zero-word status bus cannot be declared, so one unused slot is kept
    // when the write phase is disabled.
    localparam int                  WR_SLOTS   = (NUM_WR > 0) ? NUM_WR : 1
) (
    input  logic                   c,
    input  logic                   rst,
    input  logic                   en,
    reg_ram_scan_if.master         ram,
    input  logic [WR_SLOTS*DW-1:0] status_in,
    output logic [DW-1:0]          flags,
    output logic [NUM_RD*DW-1:0]   cfg,
    output logic                   cfg_update,
    output logic                   busy
);

    // The index counts RD cycles 0..NUM_RD and WR cycles 0..NUM_WR-1.
    localparam int CNT_MAX = (NUM_RD > NUM_WR) ? NUM_RD : NUM_WR;
    localparam int IW      = $clog2(CNT_MAX + 1);
    localparam logic [IW-1:0] RD_LAST = IW'(NUM_RD);
    localparam logic [IW-1:0] WR_LAST = IW'(WR_SLOTS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_RD     = 3'd2,
        ST_WR     = 3'd3,
        ST_ACK    = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [IW-1:0]         idx_r;
    logic [IW-1:0]         idx_nxt_s;
    logic [DW-1:0]         flags_r;
    logic [NUM_RD*DW-1:0]  stage_r;
    logic [NUM_RD*DW-1:0]  cfg_r;
    logic [DW-1:0]         status_word_s;
    logic [AW-1:0]         addr_s;
    logic                  wr_s;
    logic [DW-1:0]         d_s;
    logic                  go_s;

    assign go_s = (state_r == ST_CHECK) && ram.reg_ram_q[0];

    // Scan sequencing: next state and phase index
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (go_s) begin
                    state_nxt_s = ST_RD;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (idx_r == RD_LAST) begin
                    idx_nxt_s = '0;
                    if (NUM_WR == 0) begin
                        state_nxt_s = ST_ACK;
                    end else begin
                        state_nxt_s = ST_WR;
                    end
                end else begin
                    idx_nxt_s = idx_r + IW'(1);
                end
            end
            ST_WR: begin
                if (idx_r == WR_LAST) begin
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_ACK;
                end else begin
                    idx_nxt_s = idx_r + IW'(1);
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Status word selected by the write index, sampled live during WR
    always_comb begin
        status_word_s = '0;
        for (int j = 0; j < WR_SLOTS; j++) begin
            status_word_s = status_word_s |
                (status_in[j*DW +: DW] & {DW{idx_r == IW'(j)}});
        end
    end

    // RAM port decode: flags address whenever no read or write is in flight
    always_comb begin
        addr_s = AW'(FLAGS_ADDR);
        wr_s   = 1'b0;
        d_s    = '0;
        case (state_r)
            ST_RD: begin
                if (idx_r != RD_LAST) begin
                    addr_s = AW'(BASE_RD) + AW'(idx_r);
                end else begin
                    addr_s = AW'(FLAGS_ADDR);
                end
            end
            ST_WR: begin
                addr_s = AW'(BASE_WR) + AW'(idx_r);
                wr_s   = 1'b1;
                d_s    = status_word_s;
            end
            ST_ACK: begin
                if (CLR_ON_ACK) begin
                    wr_s = 1'b1;
                    d_s  = {flags_r[DW-1:1], 1'b0};
                end else begin
                    wr_s = 1'b0;
                end
            end
            default: begin
                addr_s = AW'(FLAGS_ADDR);
            end
        endcase
    end

    // State, index and flags capture
    always_ff @(posedge c) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            flags_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (go_s) begin
                flags_r <= ram.reg_ram_q;
            end
        end
    end

    // Staging bank: RD cycle k captures the word addressed in cycle k-1
    always_ff @(posedge c) begin
        if (rst) begin
            stage_r <= CFG_INIT;
        end else if (state_r == ST_RD) begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (idx_r == IW'(i + 1)) begin
                    stage_r[i*DW +: DW] <= ram.reg_ram_q;
                end
            end
        end
    end

    // Atomic publish of the whole staging bank
    always_ff @(posedge c) begin
        if (rst) begin
            cfg_r <= CFG_INIT;
        end else if (state_r == ST_COMMIT) begin
            cfg_r <= stage_r;
        end
    end

    assign ram.reg_ram_addr = addr_s;
    assign ram.reg_ram_wr   = wr_s;
    assign ram.reg_ram_d    = d_s;
    assign flags            = flags_r;
    assign cfg              = cfg_r;
    assign cfg_update       = (state_r == ST_COMMIT);
    assign busy             = go_s || (state_r == ST_RD) || (state_r == ST_WR) ||
                              (state_r == ST_ACK) || (state_r == ST_COMMIT);

endmodule
